// File: rtl/csr_master_apb_pkg.sv
// Shared types for the APB-target to CSR-master bridge: bus structs and FSM states.
package csr_master_apb_pkg;

   typedef struct packed {
      logic [31:0] paddr;
      logic        penable;
      logic        psel;
      logic        pwrite;
      logic [31:0] pwdata;
   } apb_request_t;

   typedef struct packed {
      logic [31:0] prdata;
      logic        pready;
      logic        perr;
   } apb_response_t;

   typedef struct packed {
      logic        valid;
      logic        read_not_write;
      logic [15:0] select;
      logic [15:0] address;
      logic [31:0] data;
   } csr_request_t;

   typedef struct packed {
      logic        ack;
      logic        read_data_valid;
      logic [31:0] read_data;
   } csr_response_t;

   typedef enum logic [1:0] {
      IDLE,
      REQUEST,
      ACKED,
      COMPLETE
   } state_e;

endpackage

// File: rtl/csr_master_apb_if.sv
// Bundles the APB target side and the CSR master side of the bridge.
interface csr_master_apb_if;
   import csr_master_apb_pkg::*;

   apb_request_t  apb_request;
   apb_response_t apb_response;
   csr_request_t  csr_request;
   csr_response_t csr_response;

   // master: the bridge itself (CSR master, APB target)
   modport master (
      input  apb_request,
      input  csr_response,
      output apb_response,
      output csr_request
   );

   // slave: the surrounding APB fabric and CSR targets
   modport slave (
      output apb_request,
      output csr_response,
      input  apb_response,
      input  csr_request
   );
endinterface

// File: rtl/csr_master_apb.sv
// APB target that turns each APB transfer into one CSR bus request, holding
// pready low until the CSR target completes or the timeout counter expires.
module csr_master_apb
   import csr_master_apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TIMEOUT_WIDTH  = 11
) (
   input  logic              clk,
   input  logic              clk__enable,
   input  logic              reset_n,
   csr_master_apb_if.master  bus
);

   localparam logic [TIMEOUT_WIDTH-1:0] COUNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_e                   state_q, state_d;
   logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
   csr_request_t             csr_req_q, csr_req_d;
   apb_response_t            apb_rsp_q, apb_rsp_d;

   logic timeout_hit;
   logic setup_phase;
   logic acked_done;

   assign timeout_hit = (count_q == COUNT_LAST);
   assign setup_phase = bus.apb_request.psel && !bus.apb_request.penable;
   // Reads finish on the data strobe; writes finish when the target drops ack.
   assign acked_done  = csr_req_q.read_not_write ? bus.csr_response.read_data_valid
                                                 : !bus.csr_response.ack;

   always_ff @(posedge clk) begin
      if (clk__enable) begin
         if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            csr_req_q <= '0;
            apb_rsp_q <= '0;
         end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            csr_req_q <= csr_req_d;
            apb_rsp_q <= apb_rsp_d;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      csr_req_d = csr_req_q;
      apb_rsp_d = apb_rsp_q;

      unique case (state_q)
         IDLE: begin
            if (setup_phase) begin
               csr_req_d.valid          = 1'b1;
               csr_req_d.read_not_write = !bus.apb_request.pwrite;
               csr_req_d.select         = bus.apb_request.paddr[31:16];
               csr_req_d.address        = bus.apb_request.paddr[15:0];
               csr_req_d.data           = bus.apb_request.pwdata;
               count_d                  = '0;
               state_d                  = REQUEST;
            end
         end

         REQUEST: begin
            if (bus.csr_response.ack) begin
               csr_req_d.valid = 1'b0;
               count_d         = '0;
               state_d         = ACKED;
            end else if (timeout_hit) begin
               csr_req_d.valid  = 1'b0;
               apb_rsp_d.pready = 1'b1;
               apb_rsp_d.perr   = 1'b1;
               apb_rsp_d.prdata = '0;
               state_d          = COMPLETE;
            end else begin
               count_d = count_q + TIMEOUT_WIDTH'(1);
            end
         end

         ACKED: begin
            if (acked_done) begin
               apb_rsp_d.pready = 1'b1;
               apb_rsp_d.perr   = 1'b0;
               apb_rsp_d.prdata = csr_req_q.read_not_write ? bus.csr_response.read_data : '0;
               state_d          = COMPLETE;
            end else if (timeout_hit) begin
               apb_rsp_d.pready = 1'b1;
               apb_rsp_d.perr   = 1'b1;
               apb_rsp_d.prdata = '0;
               state_d          = COMPLETE;
            end else begin
               count_d = count_q + TIMEOUT_WIDTH'(1);
            end
         end

         COMPLETE: begin
            apb_rsp_d = '0;
            state_d   = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.csr_request  = csr_req_q;
   assign bus.apb_response = apb_rsp_q;

endmodule

// File: tb/tb_csr_master_apb.sv
// Directed bench for csr_master_apb: a default-timeout instance with a simple
// CSR target model, plus a 16-cycle-timeout instance for the abort paths.
module tb_csr_master_apb;
   import csr_master_apb_pkg::*;

   logic clk = 1'b0;
   logic en;
   logic reset_n;
   always #5 clk = ~clk;

   csr_master_apb_if bus_m ();
   csr_master_apb_if bus_t ();

   csr_master_apb dut_m (
      .clk         (clk),
      .clk__enable (en),
      .reset_n     (reset_n),
      .bus         (bus_m)
   );

   csr_master_apb #(.TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(5)) dut_t (
      .clk         (clk),
      .clk__enable (en),
      .reset_n     (reset_n),
      .bus         (bus_t)
   );

   // use_to steers stimulus and observation to the short-timeout instance
   logic          use_to;
   apb_request_t  apb_req;
   apb_response_t rsp;
   csr_request_t  csr;
   csr_response_t tgt_rsp;

   assign bus_m.apb_request  = use_to ? '0 : apb_req;
   assign bus_t.apb_request  = use_to ? apb_req : '0;
   assign bus_m.csr_response = use_to ? '0 : tgt_rsp;
   assign bus_t.csr_response = use_to ? tgt_rsp : '0;
   assign rsp = use_to ? bus_t.apb_response : bus_m.apb_response;
   assign csr = use_to ? bus_t.csr_request  : bus_m.csr_request;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // CSR target: acks the cycle after valid, holds ack hold_len cycles after valid falls
   logic        tgt_en;
   int          hold_len;
   logic [31:0] tgt_rdata;
   int          tstate = 0;
   int          hold_cnt = 0;

   initial tgt_rsp = '0;
   always @(negedge clk) begin
      tgt_rsp.read_data_valid = 1'b0;
      tgt_rsp.read_data       = '0;
      if (!reset_n || !tgt_en) begin
         tstate      = 0;
         hold_cnt    = 0;
         tgt_rsp.ack = 1'b0;
      end else begin
         case (tstate)
            0: if (csr.valid) tstate = 1;
            1: begin
               tgt_rsp.ack = 1'b1;
               hold_cnt    = 0;
               tstate      = 2;
            end
            2: if (!csr.valid) begin
               hold_cnt++;
               if (hold_cnt > hold_len) begin
                  tgt_rsp.ack = 1'b0;
                  if (csr.read_not_write) begin
                     tgt_rsp.read_data_valid = 1'b1;
                     tgt_rsp.read_data       = tgt_rdata;
                  end
                  tstate = 3;
               end
            end
            default: tstate = 0;
         endcase
      end
   end

   // Bus monitor: request count, valid length, captured fields, protocol flags
   int           req_count = 0, cur_len = 0, last_len = 0;
   int           rsp_bad = 0, pready_long = 0, unstable = 0;
   logic         prev_valid = 1'b0, prev_pready = 1'b0;
   csr_request_t prev_csr = '0, cap = '0;

   always @(negedge clk) begin
      if (csr.valid) begin
         if (!prev_valid) begin
            req_count++;
            cur_len = 1;
            cap     = csr;
         end else begin
            cur_len++;
            if (csr != prev_csr) unstable++;
         end
      end else if (prev_valid) begin
         last_len = cur_len;
      end
      if (!rsp.pready && (rsp.prdata != 0 || rsp.perr)) rsp_bad++;
      if (rsp.pready && prev_pready) pready_long++;
      prev_valid  = csr.valid;
      prev_pready = rsp.pready;
      prev_csr    = csr;
   end

   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int gap_at, output logic [31:0] rdata, output logic err,
                           output int lat);
      bit done = 0;
      rdata = '0;
      err   = 1'b0;
      lat   = 0;
      @(negedge clk);
      apb_req.psel    = 1'b1;
      apb_req.penable = 1'b0;
      apb_req.pwrite  = wr;
      apb_req.paddr   = addr;
      apb_req.pwdata  = wdata;
      for (int c = 1; c <= 300 && !done; c++) begin
         @(negedge clk);
         apb_req.penable = 1'b1;
         if (c == gap_at)     en = 1'b0;
         if (c == gap_at + 4) en = 1'b1;
         if (rsp.pready) begin
            done  = 1;
            lat   = c;
            rdata = rsp.prdata;
            err   = rsp.perr;
         end
      end
      if (!done) check("xfer_completes", 32'd0, 32'd1);
      $display("xfer %s addr=0x%08h wdata=0x%08h -> prdata=0x%08h perr=%0d latency=%0d",
               wr ? "WR" : "RD", addr, wdata, rdata, err, lat);
      @(posedge clk);
      apb_req.psel    = 1'b0;
      apb_req.penable = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat, lat1, r0;

   initial begin
      en        = 1'b1;
      reset_n   = 1'b0;
      apb_req   = '0;
      use_to    = 1'b0;
      tgt_en    = 1'b1;
      hold_len  = 1;
      tgt_rdata = '0;

      repeat (3) @(negedge clk);
      check("reset_prdata", rsp.prdata, 32'd0);
      check("reset_pready", {31'd0, rsp.pready}, 32'd0);
      check("reset_perr",   {31'd0, rsp.perr}, 32'd0);
      check("reset_valid",  {31'd0, csr.valid}, 32'd0);
      check("reset_fields", {csr.select, csr.address} | csr.data, 32'd0);
      reset_n = 1'b1;

      // Plain write
      r0 = req_count;
      apb_xfer(1'b1, 32'h0003_0010, 32'h1234_5678, -10, rd, er, lat);
      check("wr_select",  {16'd0, cap.select}, 32'd3);
      check("wr_address", {16'd0, cap.address}, 32'h10);
      check("wr_data",    cap.data, 32'h1234_5678);
      check("wr_rnw",     {31'd0, cap.read_not_write}, 32'd0);
      check("wr_valid_len", last_len, 32'd2);
      check("wr_latency", lat, 32'd5);
      check("wr_perr",    {31'd0, er}, 32'd0);
      check("wr_reqs",    req_count - r0, 32'd1);

      // Plain read
      tgt_rdata = 32'hCAFE_F00D;
      apb_xfer(1'b0, 32'h0003_0020, 32'h0, -10, rd, er, lat);
      check("rd_prdata",  rd, 32'hCAFE_F00D);
      check("rd_perr",    {31'd0, er}, 32'd0);
      check("rd_latency", lat, 32'd5);
      check("rd_rnw",     {31'd0, cap.read_not_write}, 32'd1);
      check("rd_address", {16'd0, cap.address}, 32'h20);

      // Slow target: ack held 20 cycles after valid falls
      hold_len  = 20;
      tgt_rdata = 32'h0BAD_BEEF;
      r0 = req_count;
      apb_xfer(1'b0, 32'h0007_0100, 32'h0, -10, rd, er, lat);
      check("slow_latency", lat, 32'd24);
      check("slow_reqs",    req_count - r0, 32'd1);
      check("slow_prdata",  rd, 32'h0BAD_BEEF);
      check("slow_perr",    {31'd0, er}, 32'd0);
      hold_len = 1;

      // Timeout on the 16-cycle instance with no responding target
      use_to = 1'b1;
      tgt_en = 1'b0;
      apb_xfer(1'b1, 32'h0001_0004, 32'hFFFF_FFFF, -10, rd, er, lat);
      check("to_valid_len", last_len, 32'd16);
      check("to_latency",   lat, 32'd17);
      check("to_perr",      {31'd0, er}, 32'd1);
      check("to_prdata",    rd, 32'd0);

      // Same, with clk__enable low for 4 edges while in REQUEST
      apb_xfer(1'b0, 32'h0001_0008, 32'h0, 3, rd, er, lat);
      check("gap_valid_len", last_len, 32'd20);
      check("gap_latency",   lat, 32'd21);
      check("gap_perr",      {31'd0, er}, 32'd1);

      tgt_en    = 1'b1;
      tgt_rdata = 32'h55AA_0FF0;
      apb_xfer(1'b0, 32'h0001_000C, 32'h0, -10, rd, er, lat);
      check("to_next_latency", lat, 32'd5);
      check("to_next_perr",    {31'd0, er}, 32'd0);
      check("to_next_prdata",  rd, 32'h55AA_0FF0);
      use_to = 1'b0;

      // Back-to-back write then read
      r0 = req_count;
      tgt_rdata = 32'h1357_9BDF;
      apb_xfer(1'b1, 32'h0002_0008, 32'hA5A5_0001, -10, rd, er, lat1);
      apb_xfer(1'b0, 32'h0002_000C, 32'h0, -10, rd, er, lat);
      check("b2b_lat1",   lat1, 32'd5);
      check("b2b_lat2",   lat, 32'd5);
      check("b2b_reqs",   req_count - r0, 32'd2);
      check("b2b_len",    last_len, 32'd2);
      check("b2b_prdata", rd, 32'h1357_9BDF);

      // Reset while in ACKED
      hold_len = 20;
      @(negedge clk);
      apb_req.psel    = 1'b1;
      apb_req.penable = 1'b0;
      apb_req.pwrite  = 1'b0;
      apb_req.paddr   = 32'h0005_0040;
      @(negedge clk);
      apb_req.penable = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_pre_acked", {30'd0, csr.valid, tgt_rsp.ack}, 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("rst_valid",  {31'd0, csr.valid}, 32'd0);
      check("rst_fields", {csr.select, csr.address} | csr.data, 32'd0);
      check("rst_rnw",    {31'd0, csr.read_not_write}, 32'd0);
      check("rst_rsp",    {rsp.prdata[31:2], rsp.pready, rsp.perr} | rsp.prdata, 32'd0);
      $display("reset in ACKED applied");
      apb_req.psel    = 1'b0;
      apb_req.penable = 1'b0;
      @(negedge clk);
      reset_n  = 1'b1;
      hold_len = 1;
      apb_xfer(1'b1, 32'h0009_0000, 32'hDEAD_0009, -10, rd, er, lat);
      check("post_rst_latency", lat, 32'd5);
      check("post_rst_perr",    {31'd0, er}, 32'd0);
      check("post_rst_data",    cap.data, 32'hDEAD_0009);

      check("rsp_zero_when_idle", rsp_bad, 32'd0);
      check("pready_one_cycle",   pready_long, 32'd0);
      check("fields_stable",      unstable, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/csr_master_apb.md
Name: csr_master_apb

Overview:
- APB target that bridges APB accesses onto the pipelined CSR bus as a CSR master.
- It is the inverse of the CSR-target-to-APB-master bridge: a CPU-side APB fabric can reach every CSR target on the CSR bus through it.
- An APB setup phase is converted into one CSR request. APB wait states (pready low) are held until the CSR target acks, drops ack, and returns read data if the access is a read.
- A timeout counter guarantees APB completion, with perr, when no CSR target responds.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles allowed in the REQUEST or ACKED state before the access is aborted with perr. Must be ≥2.
- TIMEOUT_WIDTH, 11: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_WIDTH.

Ports:
- clk  input  1  CSR/APB clock.
- clk__enable  input  1  clock enable; all state holds when low.
- reset_n  input  1  reset: synchronous, active-low.
- apb_request__paddr  input  32  [31:16] is the CSR select, [15:0] is the CSR address.
- apb_request__penable  input  1  APB access phase.
- apb_request__psel  input  1  APB select.
- apb_request__pwrite  input  1  1 = write.
- apb_request__pwdata  input  32  write data.
- apb_response__prdata  output  32  read data, valid when pready is high.
- apb_response__pready  output  1  access complete.
- apb_response__perr  output  1  error (timeout), valid when pready is high.
- csr_request__valid  output  1  CSR request valid.
- csr_request__read_not_write  output  1  1 = read.
- csr_request__select  output  16  target select.
- csr_request__address  output  16  register address.
- csr_request__data  output  32  write data.
- csr_response__ack  input  1  target ack, held while the target is busy.
- csr_response__read_data_valid  input  1  single-cycle read data strobe.
- csr_response__read_data  input  32  read data; zero from non-driving targets.

Behaviour:
- Reset (reset_n low at a clk edge with clk__enable high): state=IDLE; all outputs 0; timeout counter 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE
  - When psel=1 and penable=0 (setup phase), latch paddr, pwrite and pwdata into the csr_request fields.
  - Set csr_request__valid=1 and read_not_write=!pwrite; clear the counter.
  - Go to REQUEST.
- REQUEST
  - csr_request__valid is held at 1 with stable fields.
  - On ack=1: valid<=0, clear the counter, go to ACKED.
  - Else if the counter reaches TIMEOUT_CYCLES-1: valid<=0, perr<=1, prdata<=0, go to COMPLETE.
  - Otherwise increment the counter.
- ACKED
  - Write: on ack=0, go to COMPLETE with perr=0.
  - Read: on read_data_valid=1, capture read_data into prdata and go to COMPLETE. A later ack drop is not required; read_data_valid arrives with ack falling.
  - Timeout as in REQUEST: perr=1, prdata=0. The counter restarts on entry to ACKED.
- COMPLETE
  - pready=1 for exactly one cycle, with prdata and perr valid.
  - Next cycle: pready<=0, perr<=0, prdata<=0, go to IDLE.
  - A setup phase arriving in the IDLE cycle that follows is accepted normally; there is no idle cycle between APB transfers beyond the APB setup phase.
- pready is 0 in every state other than COMPLETE, so wait states are inserted automatically.
- If psel drops mid-transfer (an APB protocol violation), the CSR transaction still runs to completion and pready still pulses. No abort is made on the CSR side, so the target is never left acked.
- A setup phase seen while not in IDLE is ignored; this cannot occur legally.
- read_data_valid seen during a write or in any state other than ACKED is ignored.
- Latency, with a target that acks one cycle after valid and drops ack/pulses read_data_valid one cycle after valid falls:
  - Setup phase in cycle T0.
  - valid high in T1–T2.
  - pready high in T5.
  - The APB transfer therefore takes 6 cycles including setup.
- clk__enable low: no state, counter or output changes.

Decomposition:
- Shared package holds:
  - the apb_request, apb_response, csr_request and csr_response typedefs (already in common use);
  - the state enum {IDLE, REQUEST, ACKED, COMPLETE}.
- A single module; no sub-module is warranted. The timeout counter stays inline.

Test Plan:
- Write: paddr=0x0003_0010, pwdata=0x1234_5678, target select 3.
  - csr_request select=3, address=0x0010, data=0x12345678, read_not_write=0, valid high for exactly 2 cycles.
  - pready pulses in T5 with perr=0.
- Read: paddr=0x0003_0020; target returns 0xCAFEF00D with read_data_valid.
  - prdata=0xCAFEF00D with pready for one cycle and perr=0.
  - prdata returns to 0 the following cycle.
- Slow target: ack held for 20 cycles after valid falls.
  - pready stays 0 throughout and asserts exactly 1 cycle after ack drops.
  - Exactly one CSR request is issued.
- Timeout: TIMEOUT_CYCLES=16, no target responds.
  - valid drops after 16 cycles in REQUEST.
  - pready=1, perr=1, prdata=0 on the next cycle; the next access then works normally.
- Back-to-back: write followed immediately by a read.
  - The second setup phase is accepted in the cycle after pready.
  - There is no overlap of csr_request__valid between the two requests.
- Reset asserted in ACKED.
  - All outputs are 0 on the next enabled edge and state is IDLE.
  - A subsequent write completes normally.
